// File: rtl/ahb_bus_arbiter_pkg.sv
// Shared AHB encodings, burst-length helpers and arbiter state codes
// for the bus arbiter.
package ahb_bus_arbiter_pkg;

  localparam int unsigned AHB_NUM_MASTERS = 4;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_e;

  // Arbiter states, kept as plain codes for compatibility with existing users
  localparam logic [1:0] ARB_PARK   = 2'd0;
  localparam logic [1:0] ARB_OWNED  = 2'd1;
  localparam logic [1:0] ARB_LOCKED = 2'd2;

  // Beats remaining after the NONSEQ; INCR has no defined length
  function automatic logic [3:0] burst_beats_left(input hburst_e burst);
    logic [3:0] beats;
    case (burst)
      HBURST_WRAP4, HBURST_INCR4:   beats = 4'd3;
      HBURST_WRAP8, HBURST_INCR8:   beats = 4'd7;
      HBURST_WRAP16, HBURST_INCR16: beats = 4'd15;
      default:                      beats = 4'd0;
    endcase
    return beats;
  endfunction

  function automatic logic burst_is_fixed(input hburst_e burst);
    return (burst != HBURST_SINGLE) && (burst != HBURST_INCR);
  endfunction

endpackage

// File: rtl/ahb_bus_arbiter_rr_picker.sv
// Combinational round-robin selector: first requester strictly after ptr,
// wrapping, so the pointer's own master only wins when it is alone.
module ahb_rr_picker
  import ahb_bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = AHB_NUM_MASTERS,
  parameter int unsigned IDX_WIDTH   = 4
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IDX_WIDTH-1:0]   ptr,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [IDX_WIDTH-1:0]   idx,
  output logic                   any_req
);

  logic                   found;
  int unsigned            cand;
  logic [NUM_MASTERS-1:0] shifted;

  always_comb begin
    grant   = '0;
    idx     = '0;
    found   = 1'b0;
    cand    = 0;
    shifted = '0;
    for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
      cand    = (32'(ptr) + i) % NUM_MASTERS;
      shifted = req >> cand;
      if (!found && shifted[0]) begin
        found = 1'b1;
        grant = NUM_MASTERS'(1) << cand;
        idx   = IDX_WIDTH'(cand);
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Round-robin AHB bus arbiter: hands the bus over only at transfer
// boundaries, completes fixed bursts and keeps locked sequences intact.
module ahb_bus_arbiter
  import ahb_bus_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = AHB_NUM_MASTERS,
  parameter int unsigned HMASTER_WIDTH  = 4,
  parameter int unsigned DEFAULT_MASTER = 0
) (
  input  logic                     hclk,
  input  logic                     hreset,
  input  logic [NUM_MASTERS-1:0]   hbusreq,
  input  logic [NUM_MASTERS-1:0]   hlock,
  input  logic [1:0]               htrans,
  input  logic [2:0]               hburst,
  input  logic                     hready,
  output logic [NUM_MASTERS-1:0]   hgrant,
  output logic [HMASTER_WIDTH-1:0] hmaster,
  output logic [HMASTER_WIDTH-1:0] hmaster_data,
  output logic                     hmastlock
);

  localparam logic [NUM_MASTERS-1:0]   DEFAULT_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [HMASTER_WIDTH-1:0] DEFAULT_IDX   = HMASTER_WIDTH'(DEFAULT_MASTER);

  logic [1:0]               state_q, state_d;
  logic [NUM_MASTERS-1:0]   hgrant_q, hgrant_d;
  logic [HMASTER_WIDTH-1:0] hmaster_q, hmaster_d;
  logic [HMASTER_WIDTH-1:0] hmaster_data_q, hmaster_data_d;
  logic [HMASTER_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [3:0]               beats_left_q, beats_left_d;

  htrans_e                  trans;
  hburst_e                  burst;
  logic                     owner_req;
  logic                     owner_lock;
  logic                     accepted;
  logic                     boundary;
  logic                     rearb;
  logic [NUM_MASTERS-1:0]   win_grant;
  logic [HMASTER_WIDTH-1:0] win_idx;
  logic                     any_req;

  assign trans = htrans_e'(htrans);
  assign burst = hburst_e'(hburst);

  // The one-hot grant doubles as the owner select mask
  assign owner_req  = |(hbusreq & hgrant_q);
  assign owner_lock = |(hlock & hgrant_q);
  assign accepted   = hready && ((trans == HTRANS_NONSEQ) || (trans == HTRANS_SEQ));

  ahb_rr_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .IDX_WIDTH   (HMASTER_WIDTH)
  ) u_picker (
    .req     (hbusreq),
    .ptr     (rr_ptr_q),
    .grant   (win_grant),
    .idx     (win_idx),
    .any_req (any_req)
  );

  always_comb begin
    beats_left_d = beats_left_q;
    if (accepted) begin
      if (trans == HTRANS_NONSEQ) begin
        beats_left_d = burst_beats_left(burst);
      end else if (beats_left_q != 4'd0) begin
        beats_left_d = beats_left_q - 4'd1;
      end
    end
  end

  always_comb begin
    boundary = 1'b0;
    if (hready) begin
      if (trans == HTRANS_IDLE) begin
        boundary = 1'b1;
      end else if (accepted && (trans == HTRANS_NONSEQ) && (burst == HBURST_SINGLE)) begin
        boundary = 1'b1;
      end else if (accepted && (trans == HTRANS_SEQ) && burst_is_fixed(burst) &&
                   (beats_left_q == 4'd1)) begin
        boundary = 1'b1;
      end else if ((burst == HBURST_INCR) && !owner_req && (trans != HTRANS_BUSY)) begin
        boundary = 1'b1;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    hgrant_d       = hgrant_q;
    hmaster_d      = hmaster_q;
    rr_ptr_d       = rr_ptr_q;
    hmaster_data_d = hready ? hmaster_q : hmaster_data_q;
    rearb          = 1'b0;

    if (boundary) begin
      case (state_q)
        ARB_PARK:   rearb = 1'b1;
        ARB_OWNED: begin
          if (owner_lock && owner_req) begin
            state_d = ARB_LOCKED;
          end else begin
            rearb = 1'b1;
          end
        end
        ARB_LOCKED: rearb = !owner_lock;
        default:    rearb = 1'b1;
      endcase
    end

    if (rearb) begin
      if (any_req) begin
        state_d   = ARB_OWNED;
        hgrant_d  = win_grant;
        hmaster_d = win_idx;
        rr_ptr_d  = win_idx;
      end else begin
        state_d   = ARB_PARK;
        hgrant_d  = DEFAULT_GRANT;
        hmaster_d = DEFAULT_IDX;
        rr_ptr_d  = DEFAULT_IDX;
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q        <= ARB_PARK;
      hgrant_q       <= DEFAULT_GRANT;
      hmaster_q      <= DEFAULT_IDX;
      hmaster_data_q <= DEFAULT_IDX;
      rr_ptr_q       <= DEFAULT_IDX;
      beats_left_q   <= '0;
    end else begin
      state_q        <= state_d;
      hgrant_q       <= hgrant_d;
      hmaster_q      <= hmaster_d;
      hmaster_data_q <= hmaster_data_d;
      rr_ptr_q       <= rr_ptr_d;
      beats_left_q   <= beats_left_d;
    end
  end

  assign hgrant       = hgrant_q;
  assign hmaster      = hmaster_q;
  assign hmaster_data = hmaster_data_q;
  assign hmastlock    = (state_q == ARB_LOCKED);

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed vector bench for ahb_bus_arbiter: one table row per clock,
// outputs compared 1 ns after the rising edge that sampled the row.
module tb_ahb_bus_arbiter;

  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;
  localparam logic [2:0] B_SGL = 3'b000, B_INC = 3'b001, B_I4 = 3'b011, B_I8 = 3'b101;

  logic       hclk = 1'b0;
  logic       hreset;
  logic [3:0] hbusreq;
  logic [3:0] hlock;
  logic [1:0] htrans;
  logic [2:0] hburst;
  logic       hready;
  logic [3:0] hgrant;
  logic [3:0] hmaster;
  logic [3:0] hmaster_data;
  logic       hmastlock;

  int checks   = 0;
  int failures = 0;

  always #5 hclk = ~hclk;

  ahb_bus_arbiter #(
    .NUM_MASTERS    (4),
    .HMASTER_WIDTH  (4),
    .DEFAULT_MASTER (0)
  ) dut (
    .hclk         (hclk),
    .hreset       (hreset),
    .hbusreq      (hbusreq),
    .hlock        (hlock),
    .htrans       (htrans),
    .hburst       (hburst),
    .hready       (hready),
    .hgrant       (hgrant),
    .hmaster      (hmaster),
    .hmaster_data (hmaster_data),
    .hmastlock    (hmastlock)
  );

  typedef struct {
    string      name;
    logic       rst;
    logic [3:0] req;
    logic [3:0] lock;
    logic [1:0] trans;
    logic [2:0] burst;
    logic       rdy;
    logic [3:0] g;
    logic [3:0] m;
    logic [3:0] d;
    logic       l;
    int         beats;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic rst, logic [3:0] req, logic [3:0] lock,
                              logic [1:0] trans, logic [2:0] burst, logic rdy,
                              logic [3:0] g, logic [3:0] m, logic [3:0] d, logic l,
                              int beats);
    vec_t v;
    v.name = name; v.rst = rst; v.req = req; v.lock = lock; v.trans = trans;
    v.burst = burst; v.rdy = rdy; v.g = g; v.m = m; v.d = d; v.l = l; v.beats = beats;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step(logic rst, logic [3:0] req, logic [3:0] lock,
                      logic [1:0] trans, logic [2:0] burst, logic rdy);
    hreset  = rst;
    hbusreq = req;
    hlock   = lock;
    htrans  = trans;
    hburst  = burst;
    hready  = rdy;
    @(posedge hclk);
    #1;
  endtask

  task automatic chk_outs(string name, logic [3:0] g, logic [3:0] m, logic [3:0] d, logic l);
    chk({name, ".hgrant"}, 32'(hgrant), 32'(g));
    chk({name, ".hmaster"}, 32'(hmaster), 32'(m));
    chk({name, ".hmaster_data"}, 32'(hmaster_data), 32'(d));
    chk({name, ".hmastlock"}, 32'(hmastlock), 32'(l));
    chk({name, ".onehot"}, 32'($countones(hgrant)), 32'd1);
  endtask

  initial begin
    hreset = 1'b1; hbusreq = '0; hlock = '0; htrans = T_IDLE; hburst = B_SGL; hready = 1'b1;

    //              name            rst req     lock    trans   burst  rdy  grant   m  d  lk beats
    vecs.push_back(mk("rst",          1, 4'b0000, 4'b0000, T_IDLE, B_SGL, 1, 4'b0001, 0, 0, 0, 0));
    vecs.push_back(mk("park",         0, 4'b0000, 4'b0000, T_IDLE, B_SGL, 1, 4'b0001, 0, 0, 0, -1));
    vecs.push_back(mk("rr_g1",        0, 4'b1110, 4'b0000, T_IDLE, B_SGL, 1, 4'b0010, 1, 0, 0, -1));
    vecs.push_back(mk("rr_g2",        0, 4'b1110, 4'b0000, T_NSEQ, B_SGL, 1, 4'b0100, 2, 1, 0, -1));
    vecs.push_back(mk("rr_g3",        0, 4'b1110, 4'b0000, T_NSEQ, B_SGL, 1, 4'b1000, 3, 2, 0, -1));
    vecs.push_back(mk("rr_g1b",       0, 4'b1110, 4'b0000, T_NSEQ, B_SGL, 1, 4'b0010, 1, 3, 0, -1));
    vecs.push_back(mk("rr_g2b",       0, 4'b1110, 4'b0000, T_NSEQ, B_SGL, 1, 4'b0100, 2, 1, 0, -1));
    vecs.push_back(mk("rr_g3b",       0, 4'b1110, 4'b0000, T_NSEQ, B_SGL, 1, 4'b1000, 3, 2, 0, -1));
    vecs.push_back(mk("b4_g1",        0, 4'b0110, 4'b0000, T_NSEQ, B_SGL, 1, 4'b0010, 1, 3, 0, -1));
    vecs.push_back(mk("b4_nseq",      0, 4'b0110, 4'b0000, T_NSEQ, B_I4,  1, 4'b0010, 1, 1, 0, 3));
    vecs.push_back(mk("b4_wait1",     0, 4'b0110, 4'b0000, T_SEQ,  B_I4,  0, 4'b0010, 1, 1, 0, 3));
    vecs.push_back(mk("b4_wait2",     0, 4'b0110, 4'b0000, T_SEQ,  B_I4,  0, 4'b0010, 1, 1, 0, 3));
    vecs.push_back(mk("b4_beat2",     0, 4'b0110, 4'b0000, T_SEQ,  B_I4,  1, 4'b0010, 1, 1, 0, 2));
    vecs.push_back(mk("b4_beat3",     0, 4'b0110, 4'b0000, T_SEQ,  B_I4,  1, 4'b0010, 1, 1, 0, 1));
    vecs.push_back(mk("b4_beat4",     0, 4'b0110, 4'b0000, T_SEQ,  B_I4,  1, 4'b0100, 2, 1, 0, 0));
    vecs.push_back(mk("lk_first",     0, 4'b1100, 4'b0100, T_NSEQ, B_SGL, 1, 4'b0100, 2, 2, 1, -1));
    vecs.push_back(mk("lk_second",    0, 4'b1100, 4'b0100, T_NSEQ, B_SGL, 1, 4'b0100, 2, 2, 1, -1));
    vecs.push_back(mk("lk_release",   0, 4'b1000, 4'b0000, T_IDLE, B_SGL, 1, 4'b1000, 3, 2, 0, -1));
    vecs.push_back(mk("incr_g1",      0, 4'b0010, 4'b0000, T_IDLE, B_SGL, 1, 4'b0010, 1, 3, 0, -1));
    vecs.push_back(mk("incr_nseq",    0, 4'b0011, 4'b0000, T_NSEQ, B_INC, 1, 4'b0010, 1, 1, 0, -1));
    vecs.push_back(mk("incr_seq",     0, 4'b0011, 4'b0000, T_SEQ,  B_INC, 1, 4'b0010, 1, 1, 0, -1));
    vecs.push_back(mk("incr_busy",    0, 4'b0011, 4'b0000, T_BUSY, B_INC, 1, 4'b0010, 1, 1, 0, -1));
    vecs.push_back(mk("incr_dropbsy", 0, 4'b0001, 4'b0000, T_BUSY, B_INC, 1, 4'b0010, 1, 1, 0, -1));
    vecs.push_back(mk("incr_busy2",   0, 4'b0001, 4'b0000, T_BUSY, B_INC, 1, 4'b0010, 1, 1, 0, -1));
    vecs.push_back(mk("incr_wait",    0, 4'b0001, 4'b0000, T_SEQ,  B_INC, 0, 4'b0010, 1, 1, 0, -1));
    vecs.push_back(mk("incr_end",     0, 4'b0001, 4'b0000, T_SEQ,  B_INC, 1, 4'b0001, 0, 1, 0, -1));
    vecs.push_back(mk("hr_g2",        0, 4'b0101, 4'b0000, T_NSEQ, B_SGL, 1, 4'b0100, 2, 0, 0, -1));
    vecs.push_back(mk("hr_stall",     0, 4'b0101, 4'b0000, T_NSEQ, B_SGL, 0, 4'b0100, 2, 0, 0, -1));
    vecs.push_back(mk("hr_resume",    0, 4'b0101, 4'b0000, T_NSEQ, B_SGL, 1, 4'b0001, 0, 2, 0, -1));
    vecs.push_back(mk("hr_park",      0, 4'b0000, 4'b0000, T_IDLE, B_SGL, 1, 4'b0001, 0, 0, 0, -1));
    vecs.push_back(mk("b8_g1",        0, 4'b0010, 4'b0000, T_IDLE, B_SGL, 1, 4'b0010, 1, 0, 0, -1));
    vecs.push_back(mk("b8_nseq",      0, 4'b0010, 4'b0000, T_NSEQ, B_I8,  1, 4'b0010, 1, 1, 0, 7));
    vecs.push_back(mk("b8_seq1",      0, 4'b0010, 4'b0000, T_SEQ,  B_I8,  1, 4'b0010, 1, 1, 0, 6));
    vecs.push_back(mk("b8_seq2",      0, 4'b0010, 4'b0000, T_SEQ,  B_I8,  1, 4'b0010, 1, 1, 0, 5));
    vecs.push_back(mk("b8_reset",     1, 4'b0010, 4'b0000, T_SEQ,  B_I8,  1, 4'b0001, 0, 0, 0, 0));
    vecs.push_back(mk("post_rst",     0, 4'b0000, 4'b0000, T_IDLE, B_SGL, 1, 4'b0001, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].req, vecs[i].lock, vecs[i].trans, vecs[i].burst, vecs[i].rdy);
      chk_outs(vecs[i].name, vecs[i].g, vecs[i].m, vecs[i].d, vecs[i].l);
      if (vecs[i].beats >= 0)
        chk({vecs[i].name, ".beats_left"}, 32'(dut.beats_left_q), 32'(vecs[i].beats));
      if (vecs[i].rst)
        chk({vecs[i].name, ".state"}, 32'(dut.state_q), 32'd0);
    end

    // Lock taken from PARK needs a second boundary; a stalled cycle must not release it
    step(0, 4'b1000, 4'b1000, T_IDLE, B_SGL, 1);
    chk_outs("h_req_rise", 4'b1000, 4'd3, 4'd0, 1'b0);
    step(0, 4'b1001, 4'b1000, T_NSEQ, B_SGL, 1);
    chk_outs("h_lock_on", 4'b1000, 4'd3, 4'd3, 1'b1);
    step(0, 4'b1001, 4'b0000, T_NSEQ, B_SGL, 0);
    chk_outs("h_lock_stall", 4'b1000, 4'd3, 4'd3, 1'b1);
    step(0, 4'b1001, 4'b0000, T_IDLE, B_SGL, 1);
    chk_outs("h_lock_off", 4'b0001, 4'd0, 4'd3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_bus_arbiter.md
Name: ahb_bus_arbiter

Overview:
Multi-master arbiter in front of the AHB interconnect. It picks the bus owner from NUM_MASTERS requesters, round-robin. Ownership changes only at legal transfer boundaries: fixed bursts run to completion, and locked sequences are never split. It drives the one-hot grant vector plus the address-phase and data-phase HMASTER indices that steer the interconnect's address/control and hwdata multiplexers.

Parameters:
NUM_MASTERS, 4, number of requesting masters (2..16)
HMASTER_WIDTH, 4, width of master index outputs; 2**HMASTER_WIDTH >= NUM_MASTERS
DEFAULT_MASTER, 0, master parked on the bus when nobody requests; it must drive IDLE

Ports:
hclk  input  1  bus clock
hreset  input  1  synchronous, active-high reset
hbusreq  input  NUM_MASTERS  per-master bus request
hlock  input  NUM_MASTERS  per-master lock request, meaningful with hbusreq
htrans  input  2  htrans of the current address-phase owner (muxed)
hburst  input  3  hburst of the current address-phase owner (muxed)
hready  input  1  bus hready (transfer accepted when 1)
hgrant  output  NUM_MASTERS  one-hot grant
hmaster  output  HMASTER_WIDTH  address-phase owner index
hmaster_data  output  HMASTER_WIDTH  data-phase owner index (hwdata/hrdata steering)
hmastlock  output  1  current owner holds the bus locked

Behaviour:
- Reset (synchronous, wins over everything, including mid-burst):
  - hgrant=one-hot(DEFAULT_MASTER); hmaster=hmaster_data=DEFAULT_MASTER; hmastlock=0
  - state=PARK; rr_ptr=DEFAULT_MASTER; beats_left=0
- Accepted transfer: hready=1 and htrans in {NONSEQ,SEQ}. BUSY and IDLE are never "accepted".
- Beat counter:
  - On an accepted NONSEQ, load beats_left = len(hburst)-1. SINGLE=0; INCR4/WRAP4=3; INCR8/WRAP8=7; INCR16/WRAP16=15; INCR (undefined) = 0 and counter unused.
  - Accepted SEQ decrements, saturating at 0.
  - hready=0 or BUSY: counter holds.
- Boundary: asserted in the cycle where hready=1 and any of the following holds:
  - htrans==IDLE
  - accepted NONSEQ with hburst==SINGLE
  - accepted SEQ of a fixed burst with beats_left==1 (last beat)
  - hburst==INCR, owner's hbusreq==0, htrans!=BUSY
- Arbitration (computed combinationally, registered at the boundary edge):
  - Search hbusreq from rr_ptr+1, wrapping modulo NUM_MASTERS; first set bit wins.
  - If no request, winner=DEFAULT_MASTER.
  - The current owner re-wins only if it is first in rotation, i.e. it is the only requester.
- States:
  - PARK: default master owns, no requests. At a boundary with any hbusreq, go to OWNED with the winner.
  - OWNED: at a boundary:
    - if hlock[owner]&&hbusreq[owner], retain owner and go to LOCKED;
    - else regrant to the winner (stay OWNED), or go to PARK when no requests.
  - LOCKED: hmastlock=1. Rearbitration is suppressed at every boundary while hlock[owner]=1. When hlock[owner] drops, the next boundary arbitrates as in OWNED.
- Update timing:
  - hgrant and hmaster update on the clock edge that samples a boundary; latency = 1 cycle from boundary to new grant.
  - rr_ptr is set to the new owner on the same edge.
  - hmaster_data <= hmaster on every edge with hready=1; it holds when hready=0.
- Simultaneous events: a request rising in the boundary cycle is eligible. A request dropping in a non-boundary cycle has no effect until the next boundary.
- hready=0: all state, grant and counters hold.
- Invariant: hgrant is always exactly one-hot, including after reset.

Decomposition:
- Shared package (AhbGlobalPackage) gains:
  - htrans enum {IDLE,BUSY,NONSEQ,SEQ}
  - hburst enum {SINGLE,INCR,WRAP4,INCR4,WRAP8,INCR8,WRAP16,INCR16}
  - NUM_MASTERS default
  - burst-length function
  - arbiter state enum {PARK,OWNED,LOCKED}
- One sub-module, ahb_rr_picker: combinational round-robin priority selector (request vector, pointer -> one-hot winner, index, any_req).

Test Plan:
- Reset then no requests -> hgrant=4'b0001, hmaster=0, state PARK; assert hreset during an INCR8 at beat 3 -> next cycle grant returns to 4'b0001, beats_left=0.
- Masters 1,2,3 request continuously, SINGLE transfers, hready=1 -> ownership sequence 1,2,3,1,2,3, each new grant 1 cycle after its boundary.
- Master 1 issues INCR4 while master 2 requests; hready low for 2 cycles on beat 2 -> grant stays with 1 for all 4 beats (6 cycles), moves to 2 one cycle after the 4th accepted beat.
- Master 2 asserts hlock with two SINGLE transfers while master 3 requests -> hmastlock=1, no handover between the locked transfers; master 3 granted after the first boundary following hlock deassertion.
- Master 1 runs INCR with interleaved BUSY, then drops hbusreq during BUSY -> no handover until the next non-BUSY cycle with hready=1; master 0 then granted.
- hready=0 at a boundary -> hmaster_data unchanged; hmaster_data = hmaster of the prior cycle on the first hready=1 edge.
